// File: rtl/sc_stream_decoder_if.sv
// Bundle of the SC stream decoder frame controls, class bitstreams and results.
// Optional macro SC_DECODE_BIPOLAR_EN widens the score fields by one bit.
interface sc_stream_if #(
    parameter int N2    = 10,
    parameter int LEN_W = 8,
    parameter int CLS_W = 4
);
`ifdef SC_DECODE_BIPOLAR_EN
    localparam int CNT_W = LEN_W + 2;
`else
    localparam int CNT_W = LEN_W + 1;
`endif

    logic                  start;
    logic [LEN_W-1:0]      stream_len;
    logic [N2-1:0]         din;
    logic                  busy;
    logic                  done;
    logic [N2*CNT_W-1:0]   counts;
    logic [CLS_W-1:0]      class_idx;
    logic [CNT_W-1:0]      class_cnt;

    modport master (
        output start, stream_len, din,
        input  busy, done, counts, class_idx, class_cnt
    );

    modport slave (
        input  start, stream_len, din,
        output busy, done, counts, class_idx, class_cnt
    );
endinterface

// File: rtl/sc_stream_decoder.sv
// Counts per-class stochastic bitstreams over a framed window and reports the argmax class.
// Macro SC_DECODE_BIPOLAR_EN switches scores to signed 2*ones - L.
module sc_stream_decoder #(
    parameter int N2     = 10,
    parameter int LEN_W  = 8,
    parameter int WARMUP = 4,
    parameter int CLS_W  = 4
) (
    input  logic       clk,
    input  logic       reset,
    sc_stream_if.slave bus
);
`ifdef SC_DECODE_BIPOLAR_EN
    localparam int CNT_W = LEN_W + 2;
`else
    localparam int CNT_W = LEN_W + 1;
`endif

    // One phase counter times every multi-cycle state, so it must reach the longest of them.
    localparam int MAX_LEN = 1 << LEN_W;
    localparam int PH_MAX  = (MAX_LEN > WARMUP) ? ((MAX_LEN > N2) ? MAX_LEN : N2)
                                                : ((WARMUP > N2) ? WARMUP : N2);
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] WARM_LAST = PH_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [PH_W-1:0] ARG_LAST  = PH_W'(N2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_COUNT,
        S_ARGMAX,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   len_q;
    logic [CNT_W-1:0]  cnt [N2];
    logic [CLS_W-1:0]  class_idx_q;
    logic [CNT_W-1:0]  class_cnt_q;
    logic [CLS_W-1:0]  cur_idx;
    logic [CNT_W-1:0]  cand;
    logic              cand_gt;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = (WARMUP > 0) ? S_WARMUP : S_COUNT;
            end
            S_WARMUP: begin
                bus.busy = 1'b1;
                if (phase == WARM_LAST) state_nxt = S_COUNT;
            end
            S_COUNT: begin
                bus.busy = 1'b1;
                if (phase == len_q - PH_W'(1)) state_nxt = S_ARGMAX;
            end
            S_ARGMAX: begin
                bus.busy = 1'b1;
                if (phase == ARG_LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || state == S_IDLE || state_nxt != state) phase <= '0;
        else                                                 phase <= phase + PH_W'(1);
    end

    // During ARGMAX the phase counter doubles as the class being examined.
    assign cur_idx = CLS_W'(phase);
    assign cand    = cnt[cur_idx];
`ifdef SC_DECODE_BIPOLAR_EN
    assign cand_gt = $signed(cand) > $signed(class_cnt_q);
`else
    assign cand_gt = cand > class_cnt_q;
`endif

    // NOTE: the count array is reset explicitly because a reset must clear any
    // partial result; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q       <= '0;
            class_idx_q <= '0;
            class_cnt_q <= '0;
            for (int k = 0; k < N2; k++) cnt[k] <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        len_q       <= (bus.stream_len == '0) ? PH_W'(MAX_LEN)
                                                              : PH_W'(bus.stream_len);
                        class_idx_q <= '0;
                        class_cnt_q <= '0;
                        for (int k = 0; k < N2; k++) cnt[k] <= '0;
                    end
                end
                S_COUNT: begin
                    for (int k = 0; k < N2; k++) begin
`ifdef SC_DECODE_BIPOLAR_EN
                        cnt[k] <= bus.din[k] ? cnt[k] + CNT_W'(1) : cnt[k] - CNT_W'(1);
`else
                        cnt[k] <= cnt[k] + CNT_W'(bus.din[k]);
`endif
                    end
                end
                S_ARGMAX: begin
                    // Class 0 seeds the running best; later classes need a strict win.
                    if (phase == '0 || cand_gt) begin
                        class_idx_q <= cur_idx;
                        class_cnt_q <= cand;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < N2; k++) begin : g_counts
        assign bus.counts[k*CNT_W +: CNT_W] = cnt[k];
    end

    assign bus.class_idx = class_idx_q;
    assign bus.class_cnt = class_cnt_q;
endmodule
